// File: rtl/mux_2to1_rr_stage.sv
// mux_2to1_rr_stage: registered 2-channel arbitrating mux stage.
// Two valid/ready producers (a, b) share one valid/ready consumer. A combinational
// arbiter picks the winner. The winning word is captured into a one-entry output
// register. That register can drain and reload on the same edge, so the stage
// sustains one word per cycle.
//
// Configuration macro: MUX_RR_ARB_EN
//   defined   -> round-robin on contention (winner = ~last_grant)
//   undefined -> fixed priority, a always wins contention
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low
//   a_valid    channel a word present
//   a_data     channel a word
//   a_ready    channel a word accepted this cycle (combinational)
//   b_valid    channel b word present
//   b_data     channel b word
//   b_ready    channel b word accepted this cycle (combinational)
//   out_valid  out_data holds a word
//   out_data   registered mux output
//   out_sel    source of out_data: 0=a, 1=b
//   out_ready  consumer takes word when out_valid & out_ready
module mux_2to1_rr_stage #(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [width-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [width-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [width-1:0] out_data,
  output logic             out_sel,
  input  logic             out_ready
);

  logic grant_a;
  logic grant_b;
  logic can_load;
  logic load_a;
  logic load_b;

`ifdef MUX_RR_ARB_EN
  // 0 = a took the last transfer, 1 = b; reset to 1 so a wins the first contention
  logic last_grant;

  // Round-robin arbiter: on contention the channel not served last wins
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_valid && b_valid) begin
      grant_a = last_grant;
      grant_b = ~last_grant;
    end else begin
      grant_a = a_valid;
      grant_b = b_valid;
    end
  end

  // History advances only on an actual transfer, never on a bare request
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (load_a) begin
      last_grant <= 1'b0;
    end else if (load_b) begin
      last_grant <= 1'b1;
    end
  end
`else
  // Fixed priority: b is served only when a is idle
  assign grant_a = a_valid;
  assign grant_b = b_valid & ~a_valid;
`endif

  // The register is free when empty or being drained this cycle
  assign can_load = ~out_valid | out_ready;

  // rst_n gating keeps both producers stalled while reset is held
  assign a_ready = rst_n & can_load & grant_a;
  assign b_ready = rst_n & can_load & grant_b;

  assign load_a = a_valid & a_ready;
  assign load_b = b_valid & b_ready;

  // Output register: load wins over drain, so drain+load is a same-edge replace
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 1'b0;
    end else if (load_a) begin
      out_valid <= 1'b1;
      out_data  <= a_data;
      out_sel   <= 1'b0;
    end else if (load_b) begin
      out_valid <= 1'b1;
      out_data  <= b_data;
      out_sel   <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_2to1_rr_stage.sv
// tb_mux_2to1_rr_stage: directed self-checking bench for mux_2to1_rr_stage.
// Expectations follow the arbitration mode selected by MUX_RR_ARB_EN.
module tb_mux_2to1_rr_stage;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_n;
  logic         a_valid;
  logic [W-1:0] a_data;
  logic         a_ready;
  logic         b_valid;
  logic [W-1:0] b_data;
  logic         b_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_sel;
  logic         out_ready;

  int pass_cnt = 0;
  int total    = 0;

  mux_2to1_rr_stage #(.width(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
    a_data = 32'h1111_1111; b_data = 32'h2222_2222;
    tick(); tick();
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else pass_cnt++;
    total++; if (out_data !== 32'h0) $display("FAIL reset_out_data got %h exp 0", out_data); else pass_cnt++;
    total++; if (out_sel !== 1'b0) $display("FAIL reset_out_sel got %b exp 0", out_sel); else pass_cnt++;
    total++; if (a_ready !== 1'b0 || b_ready !== 1'b0)
      $display("FAIL reset_ready got a=%b b=%b exp 0 0", a_ready, b_ready); else pass_cnt++;
    a_valid = 1'b0; b_valid = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_a();
    a_valid = 1'b1; a_data = 32'hA000_0000; b_valid = 1'b0; out_ready = 1'b1;
    #1;
    total++; if (a_ready !== 1'b1 || b_ready !== 1'b0)
      $display("FAIL single_a_ready got a=%b b=%b exp 1 0", a_ready, b_ready); else pass_cnt++;
    tick();
    a_valid = 1'b0;
    total++; if (out_valid !== 1'b1) $display("FAIL single_a_valid got %b exp 1", out_valid); else pass_cnt++;
    total++; if (out_data !== 32'hA000_0000) $display("FAIL single_a_data got %h exp a0000000", out_data); else pass_cnt++;
    total++; if (out_sel !== 1'b0) $display("FAIL single_a_sel got %b exp 0", out_sel); else pass_cnt++;
    tick();
  endtask

  task automatic test_contention();
    logic         exp_sel;
    logic [W-1:0] exp_data;
    // Fresh reset so the first contention starts from the reset history
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    a_valid = 1'b1; a_data = 32'hB000_0000;
    b_valid = 1'b1; b_data = 32'hC000_0000; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef MUX_RR_ARB_EN
      exp_sel = (i % 2 == 1);
`else
      exp_sel = 1'b0;
`endif
      exp_data = exp_sel ? 32'hC000_0000 : 32'hB000_0000;
      #1;
      total++; if (b_ready !== exp_sel || a_ready !== ~exp_sel)
        $display("FAIL contention_ready[%0d] got a=%b b=%b exp a=%b b=%b", i, a_ready, b_ready, ~exp_sel, exp_sel);
      else pass_cnt++;
      tick();
      total++; if (out_valid !== 1'b1 || out_sel !== exp_sel || out_data !== exp_data)
        $display("FAIL contention_out[%0d] got v=%b sel=%b data=%h exp v=1 sel=%b data=%h",
                 i, out_valid, out_sel, out_data, exp_sel, exp_data);
      else pass_cnt++;
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    a_valid = 1'b1; a_data = 32'hD000_0000; b_valid = 1'b0; out_ready = 1'b1;
    tick();
    total++; if (out_data !== 32'hD000_0000) $display("FAIL bp_load got %h exp d0000000", out_data); else pass_cnt++;
    // Stall with a different word from b waiting
    a_valid = 1'b0; b_valid = 1'b1; b_data = 32'h1234_5678; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (a_ready !== 1'b0 || b_ready !== 1'b0)
        $display("FAIL bp_ready[%0d] got a=%b b=%b exp 0 0", i, a_ready, b_ready); else pass_cnt++;
      tick();
      total++; if (out_valid !== 1'b1 || out_data !== 32'hD000_0000 || out_sel !== 1'b0)
        $display("FAIL bp_hold[%0d] got v=%b data=%h sel=%b exp v=1 data=d0000000 sel=0",
                 i, out_valid, out_data, out_sel);
      else pass_cnt++;
    end
    out_ready = 1'b1;
    #1;
    total++; if (b_ready !== 1'b1) $display("FAIL bp_release_ready got %b exp 1", b_ready); else pass_cnt++;
    tick();
    b_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_data !== 32'h1234_5678 || out_sel !== 1'b1)
      $display("FAIL bp_replace got v=%b data=%h sel=%b exp v=1 data=12345678 sel=1", out_valid, out_data, out_sel);
    else pass_cnt++;
  endtask

  task automatic test_drain();
    a_valid = 1'b1; a_data = 32'hD000_0000; out_ready = 1'b1;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_data !== 32'hD000_0000)
      $display("FAIL drain_preload got v=%b data=%h exp v=1 data=d0000000", out_valid, out_data); else pass_cnt++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL drain_valid got %b exp 0", out_valid); else pass_cnt++;
    total++; if (out_data !== 32'hD000_0000 || out_sel !== 1'b0)
      $display("FAIL drain_hold got data=%h sel=%b exp data=d0000000 sel=0", out_data, out_sel); else pass_cnt++;
    tick();
    total++; if (out_valid !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0)
      $display("FAIL drain_idle got v=%b a=%b b=%b exp 0 0 0", out_valid, a_ready, b_ready); else pass_cnt++;
  endtask

  task automatic test_midop_reset();
    a_valid = 1'b1; a_data = 32'hE000_0000; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b1 || out_data !== 32'hE000_0000)
      $display("FAIL midrst_load got v=%b data=%h exp v=1 data=e0000000", out_valid, out_data); else pass_cnt++;
    out_ready = 1'b1; rst_n = 1'b0;
    #1;
    total++; if (a_ready !== 1'b0) $display("FAIL midrst_ready got %b exp 0", a_ready); else pass_cnt++;
    tick();
    total++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_sel !== 1'b0)
      $display("FAIL midrst_regs got v=%b data=%h sel=%b exp 0 0 0", out_valid, out_data, out_sel); else pass_cnt++;
    rst_n = 1'b1;
    a_valid = 1'b1; a_data = 32'hF000_000A; b_valid = 1'b1; b_data = 32'hF000_000B;
    #1;
    total++; if (a_ready !== 1'b1 || b_ready !== 1'b0)
      $display("FAIL midrst_grant got a=%b b=%b exp 1 0", a_ready, b_ready); else pass_cnt++;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_sel !== 1'b0 || out_data !== 32'hF000_000A)
      $display("FAIL midrst_first got v=%b sel=%b data=%h exp 1 0 f000000a", out_valid, out_sel, out_data); else pass_cnt++;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
    a_data = '0; b_data = '0;
    test_reset();
    test_single_a();
    test_contention();
    test_backpressure();
    test_drain();
    test_midop_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
